// File: rtl/alu_mdu.sv
// RV32-style ALU with iterative M-extension multiply/divide behind a valid/ready handshake.
// Base ops finish in one registered cycle; MUL/DIV iterate one bit per cycle, then a FIX cycle.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  logic [4:0]      alufn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            cf,
  output logic            zf,
  output logic            vf,
  output logic            sf,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t                state, state_nx;
  logic                  accept, m_op, is_div, div0, iter_start;
  logic                  sgn_a, sgn_b, sa, sb;
  logic [SHW-1:0]        cnt;
  logic [2*XLEN-1:0]     prod;
  logic [2*XLEN-1:0]     prod_s;
  logic [XLEN-1:0]       opr;
  logic                  neg_q, neg_r;
  logic [2:0]            fn_r;
  logic [XLEN:0]         mul_sum, div_try;

  logic [XLEN-1:0]        bx, sum;
  logic                   cout, ovf;
  logic signed [XLEN-1:0] a_s;
  logic [XLEN-1:0]        imm_res, fix_res;
  logic [3:0]             imm_flg;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign m_op       = alufn[4] & ~alufn[3];
  assign is_div     = alufn[2];
  assign div0       = m_op & is_div & (b == '0);
  assign in_ready   = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid & in_ready;
  assign iter_start = accept & m_op & ~div0;
  assign busy       = (state != IDLE);

  // Shared adder: subtraction when alufn[0] is set, also feeds SLT/SLTU
  assign bx  = alufn[0] ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{XLEN{1'b0}}, alufn[0]};
  assign ovf = a[XLEN-1] ^ bx[XLEN-1] ^ sum[XLEN-1] ^ cout;
  assign a_s = a;

  // Operand signedness: divides are signed unless alufn[0]; MULH/MULHSU sign-extend a, MULH also b
  assign sgn_a = is_div ? ~alufn[0] : (alufn[1:0] == 2'b01 || alufn[1:0] == 2'b10);
  assign sgn_b = is_div ? ~alufn[0] : (alufn[1:0] == 2'b01);
  assign sa    = sgn_a & a[XLEN-1];
  assign sb    = sgn_b & b[XLEN-1];

  always_comb begin
    imm_res = '0;
    imm_flg = 4'b0000;
    if (!alufn[4]) begin
      case (alufn[3:0])
        4'b0000, 4'b0001: begin
          imm_res = sum;
          imm_flg = {cout, sum == '0, ovf, sum[XLEN-1]};
        end
        4'b0011: imm_res = b;
        4'b0100: imm_res = a | b;
        4'b0101: imm_res = a & b;
        4'b0111: imm_res = a ^ b;
        4'b1000: imm_res = a << shamt;
        4'b1001: imm_res = a >> shamt;
        4'b1010: imm_res = a_s >>> shamt;
        4'b1101: imm_res = {{(XLEN-1){1'b0}}, sum[XLEN-1] != ovf};
        4'b1111: imm_res = {{(XLEN-1){1'b0}}, ~cout};
        default: imm_res = '0;
      endcase
    end else if (div0) begin
      imm_res = alufn[1] ? a : '1;
      imm_flg = {1'b0, imm_res == '0, 2'b00};
    end
  end

  assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opr} : '0);
  assign div_try = prod[2*XLEN-1:XLEN-1] - {1'b0, opr};

  always_comb begin
    prod_s = cneg2(prod, neg_q);
    if (fn_r[2])
      fix_res = fn_r[1] ? cneg(prod[2*XLEN-1:XLEN], neg_r) : cneg(prod[XLEN-1:0], neg_q);
    else
      fix_res = (fn_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (iter_start) state_nx = is_div ? DIV : MUL;
      MUL, DIV: if (cnt == SHW'(XLEN-1)) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Iteration datapath: prod holds {hi, lo} product, or {remainder, dividend/quotient}
  always_ff @(posedge clk) begin
    if (iter_start) begin
      prod  <= {{XLEN{1'b0}}, is_div ? cneg(a, sa) : cneg(b, sb)};
      opr   <= is_div ? cneg(b, sb) : cneg(a, sa);
      neg_q <= sa ^ sb;
      neg_r <= sa;
      fn_r  <= alufn[2:0];
      cnt   <= '0;
    end else if (state == MUL) begin
      prod <= {mul_sum, prod[XLEN-1:1]};
      cnt  <= cnt + SHW'(1);
    end else if (state == DIV) begin
      if (!div_try[XLEN]) prod <= {div_try[XLEN-1:0], prod[XLEN-2:0], 1'b1};
      else                prod <= {prod[2*XLEN-2:0], 1'b0};
      cnt <= cnt + SHW'(1);
    end
  end

  // Output register: held while out_valid && !out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      {cf, zf, vf, sf} <= 4'b0000;
      out_valid <= 1'b0;
    end else if (state == FIX) begin
      out       <= fix_res;
      {cf, zf, vf, sf} <= {1'b0, fix_res == '0, 2'b00};
      out_valid <= 1'b1;
    end else if (accept && !iter_start) begin
      out       <= imm_res;
      {cf, zf, vf, sf} <= imm_flg;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
